// File: rtl/pinball_pkg.sv
// rtl/pinball_pkg.sv - shared state encodings and target-group tables for the pinball core
package pinball_pkg;

  typedef enum logic [2:0] {
    ST_RESET = 3'd0,
    ST_WAIT  = 3'd1,
    ST_START = 3'd2,
    ST_GET   = 3'd3,
    ST_OVER  = 3'd4
  } state_e;

  localparam logic [9:0] SCORE_MAX = 10'd1023;

  // Bit 7 is the leftmost LED; a group's value is 5 minus its lit-lane count.
  localparam logic [7:0] GROUP_MASK [8] = '{
    8'b0101_0101, 8'b0100_1001, 8'b0001_0010, 8'b0010_0000,
    8'b1010_1010, 8'b1001_0010, 8'b0100_1000, 8'b0000_0100
  };

  localparam logic [2:0] POINTS [8] = '{
    3'd1, 3'd2, 3'd3, 3'd4, 3'd1, 3'd2, 3'd3, 3'd4
  };

endpackage

// File: rtl/pinball_tick_gen.sv
// rtl/pinball_tick_gen.sv - enable-gated prescaler, tick is high in the DIV-th enabled cycle
module tick_gen #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = en && !clr && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pinball_game_ctrl.sv
// rtl/pinball_game_ctrl.sv - game sequencer: attract/ready/play/reward/game-over flow, scoring, ball count
module pinball_game_ctrl
  import pinball_pkg::*;
#(
  parameter int LED_DIV     = 25_000_000,
  parameter int GROUP_DIV   = 50_000_000,
  parameter int WAIT_CYCLES = 100_000_000,
  parameter int GET_CYCLES  = 50_000_000,
  parameter int BALLS       = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_start,
  input  logic [7:0] lane_hit,
  input  logic       drain,
  output logic [2:0] state,
  output logic [7:0] selected_group,
  output logic       led_clk,
  output logic [9:0] score,
  output logic [2:0] balls_left
);

  localparam int PHASE_MAX = (WAIT_CYCLES > GET_CYCLES) ? WAIT_CYCLES : GET_CYCLES;
  localparam int PW = $clog2(PHASE_MAX + 1);
  localparam logic [PW-1:0] WAIT_LAST = PW'(WAIT_CYCLES - 1);
  localparam logic [PW-1:0] GET_LAST  = PW'(GET_CYCLES - 1);
  localparam logic [2:0]    BALLS_INIT = 3'(BALLS);

  state_e        state_q, state_d;
  logic [2:0]    group_q, group_d;
  logic [9:0]    score_q, score_d;
  logic [2:0]    balls_q, balls_d;
  logic [PW-1:0] phase_q, phase_d;
  logic          led_clk_q;

  logic          led_tick;
  logic          grp_tick;
  logic          grp_en;
  logic          grp_clr;
  logic          lit_hit;
  logic [10:0]   score_sum;

  assign grp_en  = (state_q == ST_START);
  assign grp_clr = (state_q == ST_WAIT) && (phase_q == WAIT_LAST);

  tick_gen #(.DIV(LED_DIV)) u_led_tick (
    .clk   (clk),
    .reset (reset),
    .en    (1'b1),
    .clr   (1'b0),
    .tick  (led_tick)
  );

  tick_gen #(.DIV(GROUP_DIV)) u_group_tick (
    .clk   (clk),
    .reset (reset),
    .en    (grp_en),
    .clr   (grp_clr),
    .tick  (grp_tick)
  );

  assign lit_hit   = |(lane_hit & GROUP_MASK[group_q]);
  assign score_sum = {1'b0, score_q} + 11'(POINTS[group_q]);

  always_comb begin
    state_d = state_q;
    group_d = group_q;
    score_d = score_q;
    balls_d = balls_q;
    case (state_q)
      ST_RESET: begin
        if (btn_start) begin
          state_d = ST_WAIT;
          score_d = '0;
          balls_d = BALLS_INIT;
          group_d = '0;
        end
      end
      ST_WAIT: begin
        if (phase_q == WAIT_LAST) state_d = ST_START;
      end
      ST_START: begin
        if (grp_tick) group_d = group_q + 3'd1;
        // A drain in the same cycle as a lit hit takes priority and the hit is lost.
        if (drain) begin
          if (balls_q != 3'd0) balls_d = balls_q - 3'd1;
          if (balls_q <= 3'd1) state_d = ST_OVER;
        end else if (lit_hit) begin
          score_d = (score_sum > {1'b0, SCORE_MAX}) ? SCORE_MAX : score_sum[9:0];
          state_d = ST_GET;
        end
      end
      ST_GET: begin
        if (phase_q == GET_LAST) state_d = ST_START;
        if (drain) begin
          if (balls_q != 3'd0) balls_d = balls_q - 3'd1;
          if (balls_q <= 3'd1) state_d = ST_OVER;
        end
      end
      ST_OVER: begin
        if (btn_start) state_d = ST_RESET;
      end
      default: state_d = ST_RESET;
    endcase
    phase_d = (state_d != state_q) ? '0 : phase_q + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_RESET;
      group_q   <= '0;
      score_q   <= '0;
      balls_q   <= BALLS_INIT;
      phase_q   <= '0;
      led_clk_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      group_q   <= group_d;
      score_q   <= score_d;
      balls_q   <= balls_d;
      phase_q   <= phase_d;
      led_clk_q <= led_tick;
    end
  end

  assign state          = state_q;
  assign selected_group = {5'b0, group_q};
  assign led_clk        = led_clk_q;
  assign score          = score_q;
  assign balls_left     = balls_q;

endmodule

// File: tb/tb_pinball_game_ctrl.sv
// tb/tb_pinball_game_ctrl.sv - directed and randomized bench for pinball_game_ctrl
module tb_pinball_game_ctrl;

  localparam int LED_DIV     = 4;
  localparam int GROUP_DIV   = 8;
  localparam int WAIT_CYCLES = 5;
  localparam int GET_CYCLES  = 3;
  localparam int BALLS       = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_start;
  logic [7:0] lane_hit;
  logic       drain;
  logic [2:0] state;
  logic [7:0] selected_group;
  logic       led_clk;
  logic [9:0] score;
  logic [2:0] balls_left;

  always #5 clk = ~clk;

  pinball_game_ctrl #(
    .LED_DIV     (LED_DIV),
    .GROUP_DIV   (GROUP_DIV),
    .WAIT_CYCLES (WAIT_CYCLES),
    .GET_CYCLES  (GET_CYCLES),
    .BALLS       (BALLS)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .btn_start      (btn_start),
    .lane_hit       (lane_hit),
    .drain          (drain),
    .state          (state),
    .selected_group (selected_group),
    .led_clk        (led_clk),
    .score          (score),
    .balls_left     (balls_left)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] masks [8] = '{
    8'b0101_0101, 8'b0100_1001, 8'b0001_0010, 8'b0010_0000,
    8'b1010_1010, 8'b1001_0010, 8'b0100_1000, 8'b0000_0100
  };

  int m_state, m_group, m_score, m_balls, m_cyc, m_phase, m_start, m_led;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Group is derived from the total START cycles of this game; the LED pulse from cycles since reset.
  task automatic model_step();
    int ns;
    int g;
    int pts;
    if (reset) begin
      m_state = 0; m_group = 0; m_score = 0; m_balls = BALLS;
      m_cyc = 0; m_phase = 0; m_start = 0; m_led = 0;
      return;
    end
    m_cyc++;
    m_led = (m_cyc % LED_DIV == 0) ? 1 : 0;
    ns = m_state;
    case (m_state)
      0: if (btn_start) begin
           ns = 1; m_score = 0; m_balls = BALLS; m_group = 0; m_start = 0;
         end
      1: if (m_phase + 1 == WAIT_CYCLES) ns = 2;
      2: begin
           g = m_group;
           m_start++;
           m_group = (m_start / GROUP_DIV) % 8;
           if (drain) begin
             m_balls--;
             if (m_balls == 0) ns = 4;
           end else if ((lane_hit & masks[g]) != 8'd0) begin
             pts = 5 - $countones(masks[g]);
             m_score = (m_score + pts > 1023) ? 1023 : m_score + pts;
             ns = 3;
           end
         end
      3: begin
           if (m_phase + 1 == GET_CYCLES) ns = 2;
           if (drain) begin
             m_balls--;
             if (m_balls == 0) ns = 4;
           end
         end
      4: if (btn_start) ns = 0;
      default: ns = 0;
    endcase
    m_phase = (ns != m_state) ? 0 : m_phase + 1;
    m_state = ns;
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check("state", 32'(state), m_state);
    check("group", 32'(selected_group), m_group);
    check("led_clk", 32'(led_clk), m_led);
    check("score", 32'(score), m_score);
    check("balls_left", 32'(balls_left), m_balls);
    btn_start = 1'b0;
    drain     = 1'b0;
    lane_hit  = 8'd0;
  endtask

  initial begin
    reset = 1'b1; btn_start = 1'b0; drain = 1'b0; lane_hit = 8'd0;
    step();
    step();
    check("rst_state", 32'(state), 0);
    check("rst_balls", 32'(balls_left), 3);
    reset = 1'b0;

    for (int i = 1; i <= 13; i++) begin
      step();
      check("led_phase", 32'(led_clk), (i % 4 == 0) ? 1 : 0);
    end

    btn_start = 1'b1;
    step();
    check("enter_wait", 32'(state), 1);
    repeat (4) step();
    check("still_wait", 32'(state), 1);
    step();
    check("enter_start", 32'(state), 2);

    repeat (24) step();
    check("group_3", 32'(selected_group), 3);
    lane_hit = 8'b0000_0001;
    step();
    check("unlit_state", 32'(state), 2);
    check("unlit_score", 32'(score), 0);
    lane_hit = 8'b0010_0000;
    step();
    check("hit_get", 32'(state), 3);
    check("hit_score", 32'(score), 4);
    repeat (2) step();
    check("get_hold", 32'(state), 3);
    step();
    check("get_done", 32'(state), 2);
    check("get_group", 32'(selected_group), 3);

    lane_hit = 8'b0010_0000; drain = 1'b1;
    step();
    check("drain_hit_balls", 32'(balls_left), 2);
    check("drain_hit_score", 32'(score), 4);
    check("drain_hit_state", 32'(state), 2);
    drain = 1'b1;
    step();
    check("drain2", 32'(balls_left), 1);
    drain = 1'b1;
    step();
    check("drain3_balls", 32'(balls_left), 0);
    check("drain3_over", 32'(state), 4);
    btn_start = 1'b1;
    step();
    check("over_restart", 32'(state), 0);

    for (int i = 0; i < 800; i++) begin
      btn_start = ($urandom % 6 == 0);
      drain     = ($urandom % 45 == 0);
      lane_hit  = ($urandom % 2 == 0) ? 8'($urandom) : 8'd0;
      reset     = ($urandom % 300 == 0);
      step();
      reset = 1'b0;
    end

    reset = 1'b1;
    step();
    reset = 1'b0;
    btn_start = 1'b1;
    step();
    repeat (WAIT_CYCLES) step();
    for (int i = 0; i < 6000 && m_score < 1023; i++) begin
      if (m_state == 2) lane_hit = masks[m_group];
      step();
    end
    check("sat_reached", 32'(score), 1023);
    for (int i = 0; i < 40; i++) begin
      if (m_state == 2) lane_hit = masks[m_group];
      step();
    end
    check("sat_hold", 32'(score), 1023);
    for (int i = 0; i < 50 && m_state != 3; i++) begin
      if (m_state == 2) lane_hit = masks[m_group];
      step();
    end
    check("in_get", 32'(state), 3);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midreset_state", 32'(state), 0);
    check("midreset_group", 32'(selected_group), 0);
    check("midreset_led", 32'(led_clk), 0);
    check("midreset_score", 32'(score), 0);
    check("midreset_balls", 32'(balls_left), 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
